mat_res_pack: RTL and testbench

Row packer directly downstream of `mat_accum`. It consumes the 8-bit result element stream, which carries `last` on the final element of each matrix. It emits one wide word per matrix row, with row-end and matrix-end framing. Malformed frames are reported through pulse flags, and the block always recovers to a clean matrix boundary.

---
 rtl/mat_res_pack.sv | 137 +++++++++++++
 tb/tb_mat_res_pack.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_res_pack.sv
// Row packer behind mat_accum: gathers ROW_LEN result elements into one wide word
// per matrix row, frames rows with row/matrix ends and flags short/long matrices.
module mat_res_pack #(
    parameter int DATA_W   = 8,
    parameter int ROW_LEN  = 3,
    parameter int MAT_ROWS = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_W-1:0]           s_axis_data,
    input  logic                        s_axis_valid,
    output logic                        s_axis_ready,
    input  logic                        s_axis_last,
    output logic [ROW_LEN*DATA_W-1:0]   m_axis_data,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic                        m_axis_last,
    output logic                        o_err_short,
    output logic                        o_err_long
);

    localparam int COL_W  = $clog2(ROW_LEN);
    localparam int ROW_W  = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1;
    localparam int PACK_W = (ROW_LEN - 1) * DATA_W;
    localparam int OUT_W  = ROW_LEN * DATA_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAT_ROWS - 1);

    logic [PACK_W-1:0] pack_q, pack_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic              accept, row_done, mat_end, at_final;

    // Slots below col come from the pack register, slot col is the incoming
    // element, everything above stays zero (zero padding of a short last row).
    function automatic logic [OUT_W-1:0] build_row(input logic [PACK_W-1:0] pack,
                                                   input logic [COL_W-1:0]  col,
                                                   input logic [DATA_W-1:0] elem);
        logic [OUT_W-1:0] word;
        word = '0;
        for (int i = 0; i < ROW_LEN - 1; i++) begin
            if (COL_W'(i) < col)
                word[i*DATA_W +: DATA_W] = pack[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            if (COL_W'(i) == col)
                word[i*DATA_W +: DATA_W] = elem;
        end
        return word;
    endfunction

    function automatic logic [PACK_W-1:0] write_slot(input logic [PACK_W-1:0] pack,
                                                     input logic [COL_W-1:0]  col,
                                                     input logic [DATA_W-1:0] elem);
        logic [PACK_W-1:0] res;
        res = pack;
        for (int i = 0; i < ROW_LEN - 1; i++) begin
            if (COL_W'(i) == col)
                res[i*DATA_W +: DATA_W] = elem;
        end
        return res;
    endfunction

    always_comb begin
        // No skid buffer: the input stalls whenever a held row is not being taken.
        s_axis_ready = !i_rst && (!out_valid_q || m_axis_ready);
        accept       = s_axis_valid && s_axis_ready;
        at_final     = (row_q == ROW_LAST) && (col_q == COL_LAST);
        row_done     = accept && ((col_q == COL_LAST) || s_axis_last);
        mat_end      = row_done && (s_axis_last || (row_q == ROW_LAST));

        pack_d      = pack_q;
        col_d       = col_q;
        row_d       = row_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        if (out_valid_q && m_axis_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
        end

        if (accept) begin
            if (row_done) begin
                out_data_d  = build_row(pack_q, col_q, s_axis_data);
                out_valid_d = 1'b1;
                out_last_d  = mat_end;
                col_d       = '0;
                pack_d      = '0;
                row_d       = mat_end ? '0 : row_q + ROW_W'(1);
                err_short_d = s_axis_last && !at_final;
                err_long_d  = !s_axis_last && at_final;
            end else begin
                pack_d = write_slot(pack_q, col_q, s_axis_data);
                col_d  = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pack_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign m_axis_data  = out_data_q;
    assign m_axis_valid = out_valid_q;
    assign m_axis_last  = out_last_q;
    assign o_err_short  = err_short_q;
    assign o_err_long   = err_long_q;

endmodule

// File: tb/tb_mat_res_pack.sv
// Self-checking bench for mat_res_pack: directed scenarios plus randomized traffic,
// scored against a queue-based row model of the packing rules.
module tb_mat_res_pack;

    localparam int DATA_W   = 8;
    localparam int ROW_LEN  = 3;
    localparam int MAT_ROWS = 3;
    localparam int OUT_W    = ROW_LEN * DATA_W;
    localparam int MAT_ELEM = ROW_LEN * MAT_ROWS;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [DATA_W-1:0] s_axis_data;
    logic              s_axis_valid;
    logic              s_axis_ready;
    logic              s_axis_last;
    logic [OUT_W-1:0]  m_axis_data;
    logic              m_axis_valid;
    logic              m_axis_ready;
    logic              m_axis_last;
    logic              o_err_short;
    logic              o_err_long;

    mat_res_pack #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .MAT_ROWS(MAT_ROWS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .o_err_short  (o_err_short),
        .o_err_long   (o_err_long)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
        logic             es;
        logic             el;
    } exp_t;

    exp_t     exp_q[$];
    int       part_q[$];
    int       elem_idx   = 0;
    int       rows_in_mat = 0;
    int       n_chk = 0;
    int       n_err = 0;
    int       rows_seen = 0;
    int       stalls = 0;
    int       rdy_mode = 0;
    logic     prev_valid = 1'b0;
    logic     prev_xfer  = 1'b0;
    logic     prev_last  = 1'b0;
    logic     load_due   = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: collect elements of the current row; a row closes when full or on
    // last; a matrix closes on last or on its MAT_ROWS-th row.
    function automatic logic model_accept(input logic [DATA_W-1:0] d, input logic l);
        exp_t e;
        logic closed;
        closed = 1'b0;
        part_q.push_back(int'(d));
        e.es = l && (elem_idx < MAT_ELEM - 1);
        e.el = !l && (elem_idx == MAT_ELEM - 1);
        elem_idx++;
        if (part_q.size() == ROW_LEN || l) begin
            e.data = '0;
            for (int i = 0; i < part_q.size(); i++)
                e.data[i*DATA_W +: DATA_W] = DATA_W'(part_q[i]);
            e.last = l || (rows_in_mat == MAT_ROWS - 1);
            exp_q.push_back(e);
            part_q.delete();
            closed = 1'b1;
            if (e.last) begin
                rows_in_mat = 0;
                elem_idx    = 0;
            end else begin
                rows_in_mat++;
            end
        end
        return closed;
    endfunction

    always @(posedge i_clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = !m_axis_ready;
            2:       m_axis_ready = ($urandom % 3) != 0;
            default: m_axis_ready = 1'b0;
        endcase
    end

    always @(negedge i_clk) begin
        logic new_row, xfer;
        if (i_rst) begin
            exp_q.delete();
            part_q.delete();
            elem_idx    = 0;
            rows_in_mat = 0;
            prev_valid  = 1'b0;
            prev_xfer   = 1'b0;
            load_due    = 1'b0;
        end else begin
            if (prev_valid && !prev_xfer) begin
                chk("hold_valid", 64'(m_axis_valid), 64'(1'b1));
                chk("hold_data", 64'(m_axis_data), 64'(prev_data));
                chk("hold_last", 64'(m_axis_last), 64'(prev_last));
            end
            new_row = m_axis_valid && (!prev_valid || prev_xfer);
            chk("row_latency", 64'(new_row), 64'(load_due));
            if (new_row && exp_q.size() != 0) begin
                chk("err_short", 64'(o_err_short), 64'(exp_q[0].es));
                chk("err_long", 64'(o_err_long), 64'(exp_q[0].el));
            end else begin
                chk("err_short_idle", 64'(o_err_short), 64'(1'b0));
                chk("err_long_idle", 64'(o_err_long), 64'(1'b0));
            end
            xfer = m_axis_valid && m_axis_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", 64'(m_axis_data), 64'(1'b0));
                end else begin
                    chk("row_data", 64'(m_axis_data), 64'(exp_q[0].data));
                    chk("row_last", 64'(m_axis_last), 64'(exp_q[0].last));
                    void'(exp_q.pop_front());
                    rows_seen++;
                end
            end
            prev_valid = m_axis_valid;
            prev_xfer  = xfer;
            prev_data  = m_axis_data;
            prev_last  = m_axis_last;
            load_due   = 1'b0;
            if (s_axis_valid && s_axis_ready)
                load_due = model_accept(s_axis_data, s_axis_last);
        end
    end

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_mvalid"}, 64'(m_axis_valid), 64'(1'b0));
        chk({tag, "_mlast"}, 64'(m_axis_last), 64'(1'b0));
        chk({tag, "_mdata"}, 64'(m_axis_data), 64'(1'b0));
        chk({tag, "_sready"}, 64'(s_axis_ready), 64'(1'b0));
        chk({tag, "_eshort"}, 64'(o_err_short), 64'(1'b0));
        chk({tag, "_elong"}, 64'(o_err_long), 64'(1'b0));
    endtask

    // Called at posedge+1; returns at posedge+1 after the element is taken.
    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        int  t;
        logic done;
        t    = 0;
        done = 1'b0;
        s_axis_data  = d;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        while (!done) begin
            @(negedge i_clk);
            if (s_axis_ready) done = 1'b1;
            else begin
                stalls++;
                t++;
                if (t > 200) begin
                    chk("send_timeout", 64'(t), 64'(1'b0));
                    done = 1'b1;
                end
            end
        end
        @(posedge i_clk);
        #1;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || m_axis_valid) && t < 100) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(1'b0));
    endtask

    task automatic send_nominal(input int base);
        for (int m = 0; m < MAT_ELEM; m++)
            send(DATA_W'(base + 16 * (m % ROW_LEN)), m == MAT_ELEM - 1);
    endtask

    initial begin
        int   r0, pos;
        logic l;
        i_rst        = 1'b1;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b0;
        #2;
        chk_rst_outs("reset");
        repeat (3) @(posedge i_clk);
        #3 i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Nominal matrix at full rate
        r0 = rows_seen;
        stalls = 0;
        send_nominal(16);
        chk("nominal_tput", 64'(stalls), 64'(1'b0));
        drain();
        chk("nominal_rows", 64'(rows_seen - r0), 64'(3));

        // Backpressure on the first row
        r0 = rows_seen;
        rdy_mode = 3;
        @(posedge i_clk);
        #1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        s_axis_data  = 8'h10;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b1;
        repeat (5) begin
            @(negedge i_clk);
            chk("bp_sready", 64'(s_axis_ready), 64'(1'b0));
            chk("bp_mvalid", 64'(m_axis_valid), 64'(1'b1));
            chk("bp_data", 64'(m_axis_data), 64'(24'h302010));
        end
        rdy_mode = 0;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        drain();
        chk("bp_rows", 64'(rows_seen - r0), 64'(3));

        // Short frame
        r0 = rows_seen;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b1);
        drain();
        chk("short_rows", 64'(rows_seen - r0), 64'(2));

        // Long frames: two full matrices without last
        r0 = rows_seen;
        for (int n = 0; n < 2 * MAT_ELEM; n++) send(DATA_W'(n + 1), 1'b0);
        drain();
        chk("long_rows", 64'(rows_seen - r0), 64'(6));

        // Reset in the middle of a row
        send(8'hEE, 1'b0);
        send(8'hDD, 1'b0);
        #2 i_rst = 1'b1;
        #1 chk_rst_outs("midrst_async");
        @(negedge i_clk);
        chk_rst_outs("midrst");
        @(posedge i_clk);
        #3 i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        r0 = rows_seen;
        send_nominal(8'hA1);
        drain();
        chk("postrst_rows", 64'(rows_seen - r0), 64'(3));

        // Toggling downstream ready against a continuous source
        r0 = rows_seen;
        rdy_mode = 1;
        send_nominal(5);
        send_nominal(7);
        drain();
        chk("toggle_rows", 64'(rows_seen - r0), 64'(6));

        // Randomized traffic with occasional short and long matrices
        rdy_mode = 2;
        pos = 0;
        for (int n = 0; n < 400; n++) begin
            l = 1'b0;
            if (pos == MAT_ELEM - 1) l = ($urandom % 8) != 0;
            else if (($urandom % 30) == 0) l = 1'b1;
            send(DATA_W'($urandom), l);
            pos = (l || pos == MAT_ELEM - 1) ? 0 : pos + 1;
            if (($urandom % 5) == 0) begin
                @(posedge i_clk);
                #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
